// File: rtl/regbank_pkg.sv
// Shared definitions for the register bank: primary write source encodings.
package regbank_pkg;

    typedef enum logic [1:0] {
        WB_SRC0    = 2'b00,
        WB_SRC1    = 2'b01,
        WB_SRC2    = 2'b10,
        WB_SRC_ALT = 2'b11
    } wb_src_e;

endpackage

// File: rtl/register_bank_if.sv
// Bus bundle for the register bank: two read ports, primary write, load issue/writeback, status.
interface register_bank_if #(
    parameter int N  = 32,
    parameter int AW = 4
);
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [N-1:0]  rd_data1;
    logic [N-1:0]  rd_data2;
    logic          busy1;
    logic          busy2;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [1:0]    wr_src;
    logic [N-1:0]  wdata0;
    logic [N-1:0]  wdata1;
    logic [N-1:0]  wdata2;
    logic          ld_issue;
    logic [AW-1:0] ld_addr;
    logic          ld_wb_en;
    logic [AW-1:0] ld_wb_addr;
    logic [N-1:0]  ld_wb_data;
    logic [AW:0]   pending_cnt;
    logic          ld_err;

    modport master (
        output rs, rt, wr_en, wr_addr, wr_src, wdata0, wdata1, wdata2,
               ld_issue, ld_addr, ld_wb_en, ld_wb_addr, ld_wb_data,
        input  rd_data1, rd_data2, busy1, busy2, pending_cnt, ld_err
    );

    modport slave (
        input  rs, rt, wr_en, wr_addr, wr_src, wdata0, wdata1, wdata2,
               ld_issue, ld_addr, ld_wb_en, ld_wb_addr, ld_wb_data,
        output rd_data1, rd_data2, busy1, busy2, pending_cnt, ld_err
    );
endinterface

// File: rtl/regbank_scoreboard.sv
// Tracks which registers await a load, counts them, and flags load-protocol errors.
import regbank_pkg::*;

module regbank_scoreboard #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_ok,
    input  logic [AW-1:0]    wr_addr,
    input  logic             wb_req,
    input  logic [AW-1:0]    wb_addr,
    input  logic             issue_ok,
    input  logic [AW-1:0]    issue_addr,
    output logic [DEPTH-1:0] busy_q,
    output logic             wb_valid,
    output logic [AW:0]      pending_cnt,
    output logic             ld_err
);

    logic [DEPTH-1:0] busy_d;
    logic             err_d;

    always_comb begin
        wb_valid = wb_req && busy_q[wb_addr];
        busy_d   = busy_q;
        if (wr_ok)    busy_d[wr_addr]    = 1'b0;
        if (wb_valid) busy_d[wb_addr]    = 1'b0;
        // A same-cycle issue re-arms the register after its data lands.
        if (issue_ok) busy_d[issue_addr] = 1'b1;
        err_d = ld_err
              | (wb_req & ~busy_q[wb_addr])
              | (issue_ok & busy_q[issue_addr]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            ld_err <= 1'b0;
        end else begin
            busy_q <= busy_d;
            ld_err <= err_d;
        end
    end

    always_comb begin
        pending_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_cnt = pending_cnt + {{AW{1'b0}}, busy_q[i]};
        end
    end

endmodule

// File: rtl/register_bank.sv
// Register bank with two bypassed read ports, a primary write port and load-pending tracking.
import regbank_pkg::*;

module register_bank #(
    parameter int N        = 32,
    parameter int DEPTH    = 16,
    parameter int ZERO_REG = 1
) (
    input logic           clk,
    input logic           rst,
    register_bank_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam bit ZR = (ZERO_REG != 0);

    logic [N-1:0]     regs [DEPTH];
    logic [N-1:0]     wdata_sel;
    logic             wr_ok;
    logic             wb_req;
    logic             issue_ok;
    logic             wb_valid;
    logic [DEPTH-1:0] busy_q;
    logic [AW-1:0]    raddr [2];
    logic [N-1:0]     rdata [2];
    logic             rbusy [2];

    always_comb begin
        case (wb_src_e'(bus.wr_src))
            WB_SRC1: wdata_sel = bus.wdata1;
            WB_SRC2: wdata_sel = bus.wdata2;
            default: wdata_sel = bus.wdata0;
        endcase
    end

    // Address 0 is invisible to every request when it is hardwired to zero.
    assign wr_ok    = bus.wr_en    && !(ZR && bus.wr_addr    == '0);
    assign wb_req   = bus.ld_wb_en && !(ZR && bus.ld_wb_addr == '0);
    assign issue_ok = bus.ld_issue && !(ZR && bus.ld_addr    == '0);

    regbank_scoreboard #(.DEPTH(DEPTH), .AW(AW)) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .wr_ok       (wr_ok),
        .wr_addr     (bus.wr_addr),
        .wb_req      (wb_req),
        .wb_addr     (bus.ld_wb_addr),
        .issue_ok    (issue_ok),
        .issue_addr  (bus.ld_addr),
        .busy_q      (busy_q),
        .wb_valid    (wb_valid),
        .pending_cnt (bus.pending_cnt),
        .ld_err      (bus.ld_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (wb_valid) regs[bus.ld_wb_addr] <= bus.ld_wb_data;
            // Primary write is younger and overrides a colliding writeback.
            if (wr_ok)    regs[bus.wr_addr]    <= wdata_sel;
        end
    end

    assign raddr[0] = bus.rs;
    assign raddr[1] = bus.rt;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = regs[raddr[p]];
            rbusy[p] = busy_q[raddr[p]];
            if (wb_valid && bus.ld_wb_addr == raddr[p]) begin
                rdata[p] = bus.ld_wb_data;
                rbusy[p] = 1'b0;
            end
            if (wr_ok && bus.wr_addr == raddr[p]) begin
                rdata[p] = wdata_sel;
                rbusy[p] = 1'b0;
            end
            if (ZR && raddr[p] == '0) begin
                rdata[p] = '0;
                rbusy[p] = 1'b0;
            end
        end
    end

    assign bus.rd_data1 = rdata[0];
    assign bus.rd_data2 = rdata[1];
    assign bus.busy1    = rbusy[0];
    assign bus.busy2    = rbusy[1];

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter N, default 32: data width in bits.
REQ-002 Parameter DEPTH, default 16: number of registers; power of two, at least 2.
REQ-003 Parameter ZERO_REG, default 1: when 1, register 0 reads 0 and ignores all writes and load issues.
REQ-004 Derived localparam AW = $clog2(DEPTH): register address width.
REQ-005 Clock and reset are fixed: one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 rs, rt  in  AW each  read addresses for ports 1 and 2.
REQ-009 rd_data1, rd_data2  out  N each  read data for ports 1 and 2.
REQ-010 busy1, busy2  out  1 each  addressed register is awaiting a load.
REQ-011 wr_en  in  1  primary write enable.
REQ-012 wr_addr  in  AW  primary write address.
REQ-013 wr_src  in  2  primary write source select.
REQ-014 wdata0, wdata1, wdata2  in  N each  primary write source candidates.
REQ-015 ld_issue  in  1  load issued; marks ld_addr as pending.
REQ-016 ld_addr  in  AW  destination of the issued load.
REQ-017 ld_wb_en  in  1  load writeback valid.
REQ-018 ld_wb_addr  in  AW  load writeback address.
REQ-019 ld_wb_data  in  N  load writeback data.
REQ-020 pending_cnt  out  AW+1  number of busy registers.
REQ-021 ld_err  out  1  sticky load-protocol error flag.

Function
REQ-022 wr_src encoding: 00 selects wdata0, 01 selects wdata1, 10 selects wdata2, 11 selects wdata0.
REQ-023 Primary write: on wr_en, reg[wr_addr] gets the selected data at the clock edge, and busy[wr_addr] clears (the younger write wins).
REQ-024 Load writeback: on ld_wb_en with busy[ld_wb_addr]=1, reg[ld_wb_addr] gets ld_wb_data and busy clears.
REQ-025 A load writeback to a non-busy register is discarded and sets ld_err.
REQ-026 Same-address, same-cycle primary write and load writeback: primary data is written and the busy bit clears.
REQ-027 ld_issue sets busy[ld_addr] at the edge; if it was already busy, ld_err is set and busy stays 1.
REQ-028 ld_issue together with a write or writeback to the same address in the same cycle: the data is written and busy ends at 1 (issue takes precedence).
REQ-029 Reads are combinational with write-through bypass, in this priority: primary write data, then valid load writeback data, then stored value.
REQ-030 busyN is the stored busy bit, forced 0 when a same-cycle primary write or valid writeback targets that address; the same-cycle ld_issue is not bypassed.
REQ-031 With ZERO_REG=1, address 0 reads 0 and busy 0; writes, writebacks and issues to address 0 are ignored and never set ld_err.
REQ-032 pending_cnt equals the popcount of the busy bits after each edge, maximum DEPTH (or DEPTH-1 when ZERO_REG=1).
REQ-033 ld_err is sticky until reset.

Reset
REQ-034 While rst=1 at an edge: all registers, all busy bits, pending_cnt and ld_err become 0; rst overrides all same-cycle writes and issues.
REQ-035 During and immediately after reset, outputs show 0, bypass still applies to inputs presented while rst is asserted, and pending loads are abandoned; a later writeback to them sets ld_err.

Structure
REQ-036 Shared package regbank_pkg holds the wr_src encodings WB_SRC0=2'b00, WB_SRC1=2'b01, WB_SRC2=2'b10.
REQ-037 The busy-bit array, pending counter and ld_err live in one sub-module, regbank_scoreboard; the data array and bypass stay in the top level.

Verification
REQ-038 Scenario 1: rst, then write r5=0xDEADBEEF with wr_src=00 -> same cycle rs=5 reads 0xDEADBEEF (bypass); next cycle reads it from storage.
REQ-039 Scenario 2: ld_issue r3 -> busy1=1 and pending_cnt=1; ld_wb r3=0x1234 -> that cycle busy1=0 and rd_data1=0x1234; then pending_cnt=0.
REQ-040 Scenario 3: ld_issue r7, then primary write r7=0xA5 -> busy clears; later ld_wb r7=0xFF -> discarded, r7 stays 0xA5, ld_err=1.
REQ-041 Scenario 4: primary write and ld_wb both to busy r2 in the same cycle -> r2 holds the primary data and busy=0.
REQ-042 Scenario 5: ZERO_REG=1 -> write r0=0x55 and ld_issue r0 -> r0 reads 0, busy 0, ld_err=0, pending_cnt=0.
REQ-043 Scenario 6: DEPTH-1 issues pending, then rst -> next cycle all reads 0, pending_cnt=0, ld_err=0.
